// File: rtl/bcd_display_driver_if.sv
// bcd_display_driver_if: core-to-display conversion request and digit result bundle
interface bcd_display_driver_if;
  logic       start;
  logic [7:0] data;
  logic       is_signed;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] disp0;
  logic [3:0] disp1;
  logic [3:0] disp2;
  logic [3:0] disp3;
  modport master (output start, data, is_signed, input busy, done, neg, disp0, disp1, disp2, disp3);
  modport slave  (input start, data, is_signed, output busy, done, neg, disp0, disp1, disp2, disp3);
endinterface

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: serial double-dabble of an 8-bit value into blanked decimal digits plus sign
module bcd_display_driver #(
  parameter bit         BLANK_EN   = 1'b1,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic clk,
  input logic rst,
  bcd_display_driver_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [3:0] LEAD  = BLANK_EN ? BLANK_CODE : 4'h0;
  logic [1:0]  state;
  logic [7:0]  shreg;
  logic [11:0] scr, adj;
  logic [2:0]  cnt;
  logic        sign, done, neg, hz, tz;
  logic [3:0]  disp0, disp1, disp2, disp3;
  always_comb begin
    adj = scr;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = scr[4*i +: 4] >= 4'd5 ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
  end
  assign hz = scr[11:8] == 4'd0;
  assign tz = scr[7:4] == 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      scr   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      disp0 <= 4'h0;
      disp1 <= LEAD;
      disp2 <= LEAD;
      disp3 <= LEAD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          shreg <= bus.is_signed && bus.data[7] ? ~bus.data + 8'd1 : bus.data;
          sign  <= bus.is_signed & bus.data[7];
          scr   <= '0;
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          {scr, shreg} <= {adj[10:0], shreg, 1'b0};
          cnt          <= cnt + 3'd1;
          if (cnt == 3'd7) state <= WRITE;
        end
        WRITE: begin
          disp0 <= scr[3:0];
          disp1 <= BLANK_EN && hz && tz ? BLANK_CODE : scr[7:4];
          disp2 <= BLANK_EN && hz ? BLANK_CODE : scr[11:8];
          disp3 <= LEAD;
          neg   <= sign && scr != 12'd0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy  = state != IDLE;
  assign bus.done  = done;
  assign bus.neg   = neg;
  assign bus.disp0 = disp0;
  assign bus.disp1 = disp1;
  assign bus.disp2 = disp2;
  assign bus.disp3 = disp3;
endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Output stage that converts an 8-bit result from the 8-bit processor core into decimal digits for the four seg7 display instances. The block sits between the core and the seg7 drivers and feeds their 4-bit digit and sign inputs. It takes one value per start pulse, converts it with a serial double-dabble (shift-and-add-3) over 8 iterations, and then updates all digit registers at once. An optional two's-complement mode yields a magnitude plus a separate sign flag, and leading zeros are blanked.

## Interface
- BLANK_EN, 1, 1 = replace leading-zero digits with BLANK_CODE; 0 = show zeros
- BLANK_CODE, 4'hF, digit code that the seg7 stage renders as an unlit digit
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  request conversion of `data`; sampled only in IDLE
- data  in  8  value to convert
- is_signed  in  1  sampled with start; 1 = treat `data` as two's complement
- busy  out  1  high while a conversion is in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse when new digits appear on disp0..disp3
- neg  out  1  sign of the last converted value, routed to seg7 `sinal`
- disp0  out  4  ones digit
- disp1  out  4  tens digit
- disp2  out  4  hundreds digit
- disp3  out  4  thousands digit; always zero or blank (range ≤ 255)

## Operation
- States: IDLE, CONV, WRITE.
- IDLE:
  - When start = 1, capture the magnitude into an 8-bit shift register: `data` if is_signed = 0 or data[7] = 0, else (~data + 1) mod 256, so −128 gives 128.
  - Capture a pending sign as is_signed & data[7].
  - Clear the 12-bit BCD scratch register and iteration counter, then go to CONV.
- CONV, one iteration per cycle:
  - Add 3 to each scratch BCD nibble that is ≥ 5.
  - Shift {scratch, shreg} left by 1.
  - Increment the 3-bit counter. After the 8th iteration (counter wraps 7 → 0), go to WRITE.
- WRITE:
  - Load disp0..disp2 from the scratch nibbles and set disp3 = 0.
  - Load neg from the pending sign. A zero magnitude always gives neg = 0.
  - Apply blanking if BLANK_EN: disp3 always becomes BLANK_CODE; disp2 is blanked if hundreds = 0; disp1 is blanked if hundreds = 0 and tens = 0; disp0 is never blanked.
  - Pulse done and return to IDLE.
- start outside IDLE is ignored. There is no queueing, and `data` is not re-sampled.
- Digit outputs and neg hold their value between conversions and change only in WRITE.
- Reset values:
  - state = IDLE, busy = 0, done = 0, neg = 0, disp0 = 0.
  - disp1..disp3 = BLANK_CODE if BLANK_EN, else 0.
  - Scratch registers and counter = 0.
- Reset mid-conversion aborts the conversion: no done pulse, and outputs take their reset values. rst has priority over start in the same cycle.

## Timing
- Reference cycle 0 is the cycle in which start = 1 is sampled in IDLE.
- Cycles 1..8: CONV, busy = 1.
- Cycle 9: WRITE, busy = 1.
- Cycle 10: new disp0..disp3 and neg are valid, done = 1 for exactly this cycle, busy = 0.
- Fixed latency of 10 cycles from start to done. A start in cycle 10 is accepted, giving back-to-back throughput of one conversion per 10 cycles.
- busy, done, neg and disp* are all registered, with no combinational path from inputs.
- disp* are stable for the whole cycle in which done = 1.

## Test plan
- Unsigned: after reset, start with data = 8'hFF, is_signed = 0 → at cycle 10, done = 1, disp3..0 = F,2,5,5, neg = 0; busy high cycles 1..9 only.
- Signed extreme: data = 8'h80, is_signed = 1 → disp3..0 = F,1,2,8, neg = 1. Then data = 8'hF6, is_signed = 1 → F,F,1,0, neg = 1.
- Zero and blanking:
  - data = 8'h00, is_signed = 1 → F,F,F,0, neg = 0.
  - Rebuild with BLANK_EN = 0 and convert data = 8'd7 → 0,0,0,7.
- Ignored start: start with data = 8'd42, then start with data = 8'd99 in cycle 4 → only one done, at cycle 10, showing F,F,4,2; no second done.
- Reset mid-operation: start with data = 8'd200 and assert rst in cycle 5 → no done pulse ever; busy = 0 and disp3..0 = F,F,F,0 from the cycle after reset; a subsequent start converts correctly.
- Back-to-back: start with 8'd15 in cycle 0 and 8'd250 in cycle 10 → done in cycles 10 and 20 with F,F,1,5 and then F,2,5,0.
